insn_encoder_writer: RTL and testbench
======================================

// Module: insn_encoder_writer
// PURPOSE
//  Inverse of the CPU instruction decoder: accepts an abstract instruction (ALU op, Rdest, Rsrc, 16-bit imm, R/I select).
//  Emits the 16-bit machine word(s) the decoder consumes and writes them to instruction memory at a
//  self-incrementing address. Sits between the debug/program-load front end and the instruction RAM write port.
//  A wide MOV immediate expands into LUI+ORI; all other illegal or unencodable requests are flagged and dropped.
// PARAMETERS
//  ADDR_W  8    instruction memory address width
//  DEPTH   256  words writable from base before full (DEPTH <= 2**ADDR_W)
// PORTS
//  clk         in   1       system clock, rising edge
//  reset_n     in   1       asynchronous active-low reset
//  addr_load   in   1       pulse: load write pointer from base_addr, clear full/count/errors
//  base_addr   in   ADDR_W  start address sampled on addr_load
//  in_valid    in   1       request valid
//  in_ready    out  1       request accepted when in_valid & in_ready
//  in_op       in   8       ALU op code, same 8-bit values the decoder emits (ADD 8'h05 ... ASHU 8'h86)
//  in_rdest    in   4       destination register
//  in_rsrc     in   4       source register (register form only)
//  in_imm      in   16      immediate (immediate form only)
//  in_ri       in   1       0 = register form, 1 = immediate form
//  mem_we      out  1       write strobe to instruction RAM
//  mem_addr    out  ADDR_W  write address
//  mem_wdata   out  16      encoded instruction word
//  word_count  out  ADDR_W+1  words written since last addr_load/reset
//  full        out  1       DEPTH words written; input blocked
//  err_illegal out  1       sticky: unsupported op/form seen
//  err_range   out  1       sticky: immediate not encodable
// BEHAVIOUR
//  Reset (async, reset_n=0): state ONE; mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, full=0, errors=0; in_ready=0 while in reset.
//  Encoding: register form {op[7:4],rd,op[3:0],rs}, valid for ADD,SUB,MUL,OR,CMP,AND,XOR,MOV,LSH,ASHU.
//   Immediate form {opc,rd,imm[7:0]}: ADD 5,SUB 9,CMP B,MUL E (signed: imm[15:7] all equal); AND 1,OR 2,XOR 3 (imm[15:8]==0).
//   SUBI imm is placed raw; the decoder does the inversion. MOV: imm[15:8]==0 -> {D,rd,imm[7:0]}; else two words
//   {F,rd,imm[15:8]} (LUI) then {2,rd,imm[7:0]} (ORI).
//  Illegal: any other in_op, or LSH/ASHU with in_ri=1 -> handshake completes, no write, err_illegal=1.
//  Range fail -> handshake completes, no write, err_range=1. Errors sticky until addr_load/reset.
//  FSM ONE: in_ready = ~full. On accept of a legal word: next cycle mem_we=1, mem_addr=ptr, mem_wdata=word (latency 1).
//   Wide MOV: go to TWO; in_ready=0.
//  FSM TWO: mem_we=1 with ORI word at ptr+1 (second write one cycle after LUI); return to ONE; in_ready=0 this cycle.
//  mem_we is a single-cycle strobe per word; mem_addr/mem_wdata hold their last values when mem_we=0.
//  Pointer: increments by 1 after each write, wraps modulo 2**ADDR_W. full=1 once word_count==DEPTH; no further accepts.
//  Wide MOV accepted only if word_count<=DEPTH-2; with exactly one slot left -> err_range, no write.
//  addr_load has priority over everything: ptr<=base_addr, count/full/errors cleared, a pending TWO word is
//   discarded (no write), state->ONE, in_ready=0 in the load cycle; a simultaneous request is not accepted.
//  Back-to-back single-word requests sustain 1 word/clk.
// STRUCTURE
//  Shared include cpu_isa_defs.vh: 8-bit ALU op codes (shared with the decoder), 4-bit immediate opcodes
//   (ADDI..MOVI, LUI=4'hF), and the register/immediate field positions.
//  Sub-module insn_field_encoder (combinational): op/rd/rs/imm/ri -> word0, word1, two_word, illegal, range_err.
//  Top level holds the FSM, pointer, counter, flags and output registers.
// TESTING
//  Load base 8'h10, ADD rd=3 rs=5 ri=0 -> next cycle mem_we, addr 8'h10, data 16'h0355; word_count=1.
//  ADD imm rd=2 imm=16'hFFFD, then AND imm rd=1 imm=16'h00F0 back-to-back -> 16'h52FD @11, 16'h11F0 @12, in_ready stays 1.
//  MOV imm rd=4 imm=16'h1234 -> 16'hF412 @n, 16'h2434 @n+1 on consecutive cycles, in_ready low one cycle.
//  ADD imm 16'h0080 -> err_range=1, no write; LSH ri=1 -> err_illegal=1, no write; addr_load clears both.
//  DEPTH=4, base 8'hFE: four writes land at FE,FF,00,01, then full=1, in_ready=0; a wide MOV at count 3 -> err_range.
//  Assert addr_load during TWO -> no ORI write, pointer=base; reset_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/insn_encoder_writer_pkg.sv
// insn_encoder_writer_pkg: ALU/immediate opcodes and word packing shared by the encoder and the memory writer.
package insn_encoder_writer_pkg;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;
  localparam logic [3:0] IOP_ANDI = 4'h1;
  localparam logic [3:0] IOP_ORI  = 4'h2;
  localparam logic [3:0] IOP_XORI = 4'h3;
  localparam logic [3:0] IOP_ADDI = 4'h5;
  localparam logic [3:0] IOP_SUBI = 4'h9;
  localparam logic [3:0] IOP_CMPI = 4'hB;
  localparam logic [3:0] IOP_MOVI = 4'hD;
  localparam logic [3:0] IOP_MULI = 4'hE;
  localparam logic [3:0] IOP_LUI  = 4'hF;
  typedef enum logic {ST_ONE, ST_TWO} state_t;
  typedef enum logic [1:0] {IMM_NONE, IMM_SIGNED, IMM_UNSIGNED, IMM_MOV} imm_kind_t;
  function automatic logic [15:0] pack_imm(input logic [3:0] opc, input logic [3:0] rd, input logic [7:0] imm8);
    return {opc, rd, imm8};
  endfunction
endpackage

// File: rtl/insn_encoder_writer_field_enc.sv
// insn_encoder_writer_field_enc: combinational op/operand -> machine word(s) with legality and range flags.
module insn_encoder_writer_field_enc
  import insn_encoder_writer_pkg::*;
(
  input  logic [7:0]  i_op,
  input  logic [3:0]  i_rdest,
  input  logic [3:0]  i_rsrc,
  input  logic [15:0] i_imm,
  input  logic        i_ri,
  output logic [15:0] o_word0,
  output logic [15:0] o_word1,
  output logic        o_two_word,
  output logic        o_illegal,
  output logic        o_range_err
);
  logic [3:0] w_iop;
  imm_kind_t  w_kind;
  logic       w_reg_ok;
  logic       w_sext_ok;
  logic       w_zext_ok;
  always_comb begin
    w_iop    = 4'h0;
    w_kind   = IMM_NONE;
    w_reg_ok = 1'b1;
    case (i_op)
      OP_ADD:  begin w_iop = IOP_ADDI; w_kind = IMM_SIGNED;   end
      OP_SUB:  begin w_iop = IOP_SUBI; w_kind = IMM_SIGNED;   end
      OP_CMP:  begin w_iop = IOP_CMPI; w_kind = IMM_SIGNED;   end
      OP_MUL:  begin w_iop = IOP_MULI; w_kind = IMM_SIGNED;   end
      OP_AND:  begin w_iop = IOP_ANDI; w_kind = IMM_UNSIGNED; end
      OP_OR:   begin w_iop = IOP_ORI;  w_kind = IMM_UNSIGNED; end
      OP_XOR:  begin w_iop = IOP_XORI; w_kind = IMM_UNSIGNED; end
      OP_MOV:  begin w_iop = IOP_MOVI; w_kind = IMM_MOV;      end
      OP_LSH, OP_ASHU: w_kind = IMM_NONE;
      default: w_reg_ok = 1'b0;
    endcase
  end
  // 8-bit signed field: bits 15..7 must all be copies of the sign
  assign w_sext_ok   = (&i_imm[15:7]) | ~(|i_imm[15:7]);
  assign w_zext_ok   = ~(|i_imm[15:8]);
  assign o_illegal   = ~w_reg_ok | (i_ri & (w_kind == IMM_NONE));
  assign o_two_word  = i_ri & (w_kind == IMM_MOV) & ~w_zext_ok;
  assign o_range_err = i_ri & ((w_kind == IMM_SIGNED) ? ~w_sext_ok : (w_kind == IMM_UNSIGNED) ? ~w_zext_ok : 1'b0);
  assign o_word0     = ~i_ri      ? {i_op[7:4], i_rdest, i_op[3:0], i_rsrc} :
                       o_two_word ? pack_imm(IOP_LUI, i_rdest, i_imm[15:8]) :
                                    pack_imm(w_iop, i_rdest, i_imm[7:0]);
  assign o_word1     = pack_imm(IOP_ORI, i_rdest, i_imm[7:0]);
endmodule

// File: rtl/insn_encoder_writer.sv
// insn_encoder_writer: encodes abstract instructions and streams them into instruction RAM at an auto-incrementing pointer.
module insn_encoder_writer
  import insn_encoder_writer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_op,
  input  logic [3:0]        in_rdest,
  input  logic [3:0]        in_rsrc,
  input  logic [15:0]       in_imm,
  input  logic              in_ri,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err_illegal,
  output logic              err_range
);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [15:0]       r_word1;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_ill;
  logic              r_rng;
  logic [15:0]       w_word0;
  logic [15:0]       w_word1;
  logic              w_two;
  logic              w_ill;
  logic              w_rng;
  logic              w_accept;
  logic              w_room2;
  insn_encoder_writer_field_enc u_enc (
    .i_op        (in_op),
    .i_rdest     (in_rdest),
    .i_rsrc      (in_rsrc),
    .i_imm       (in_imm),
    .i_ri        (in_ri),
    .o_word0     (w_word0),
    .o_word1     (w_word1),
    .o_two_word  (w_two),
    .o_illegal   (w_ill),
    .o_range_err (w_rng)
  );
  assign full        = r_count == DEPTH_C;
  assign in_ready    = reset_n & ~addr_load & (r_state == ST_ONE) & ~full;
  assign w_accept    = in_valid & in_ready;
  assign w_room2     = r_count <= DEPTH_C - (ADDR_W+1)'(2);
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign word_count  = r_count;
  assign err_illegal = r_ill;
  assign err_range   = r_rng;
  // addr_load outranks a pending ORI, which is why it is tested first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_ONE;
      r_ptr   <= '0;
      r_count <= '0;
      r_word1 <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ill   <= 1'b0;
      r_rng   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (addr_load) begin
        r_ptr   <= base_addr;
        r_count <= '0;
        r_ill   <= 1'b0;
        r_rng   <= 1'b0;
        r_state <= ST_ONE;
      end else if (r_state == ST_TWO) begin
        r_we    <= 1'b1;
        r_addr  <= r_ptr;
        r_wdata <= r_word1;
        r_ptr   <= r_ptr + PTR_ONE;
        r_count <= r_count + CNT_ONE;
        r_state <= ST_ONE;
      end else if (w_accept) begin
        if (w_ill) r_ill <= 1'b1;
        else if (w_rng | (w_two & ~w_room2)) r_rng <= 1'b1;
        else begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= w_word0;
          r_word1 <= w_word1;
          r_ptr   <= r_ptr + PTR_ONE;
          r_count <= r_count + CNT_ONE;
          r_state <= w_two ? ST_TWO : ST_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_insn_encoder_writer.sv
// tb_insn_encoder_writer: directed and random requests checked cycle by cycle against an arithmetic reference model.
module tb_insn_encoder_writer;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        addr_load = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_op = 8'h00;
  logic [3:0]  in_rdest = 4'h0;
  logic [3:0]  in_rsrc = 4'h0;
  logic [15:0] in_imm = 16'h0000;
  logic        in_ri = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  word_count;
  logic        full;
  logic        err_illegal;
  logic        err_range;
  int checks = 0;
  int errors = 0;
  int m_base, m_count, x_addr;
  bit m_ill, m_rng, m_two, x_we;
  logic [15:0] m_ori, x_data;
  logic [7:0] ops [12] = '{8'h05, 8'h09, 8'h0B, 8'h0E, 8'h01, 8'h02, 8'h03, 8'h0D, 8'h84, 8'h86, 8'h06, 8'hFF};

  insn_encoder_writer #(.ADDR_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .addr_load(addr_load), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rdest(in_rdest),
    .in_rsrc(in_rsrc), .in_imm(in_imm), .in_ri(in_ri), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .full(full), .err_illegal(err_illegal), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the instruction-set rules using integer arithmetic.
  function automatic void encode(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                                 input logic [15:0] imm, input bit ri, output bit ill, output bit rng,
                                 output int nw, output logic [15:0] w0, output logic [15:0] w1);
    int s, u, opc;
    bit sgn;
    s = int'($signed(imm));
    u = int'(imm);
    opc = 0;
    sgn = 0;
    ill = 0;
    rng = 0;
    nw = 1;
    w0 = 16'h0;
    w1 = 16'h0;
    if (!(op inside {8'h01, 8'h02, 8'h03, 8'h05, 8'h09, 8'h0B, 8'h0D, 8'h0E, 8'h84, 8'h86})) begin
      ill = 1;
      return;
    end
    if (!ri) begin
      w0 = 16'((int'(op) / 16) * 4096 + int'(rd) * 256 + (int'(op) % 16) * 16 + int'(rs));
      return;
    end
    case (op)
      8'h05: begin opc = 5;  sgn = 1; end
      8'h09: begin opc = 9;  sgn = 1; end
      8'h0B: begin opc = 11; sgn = 1; end
      8'h0E: begin opc = 14; sgn = 1; end
      8'h01: opc = 1;
      8'h02: opc = 2;
      8'h03: opc = 3;
      8'h0D: opc = 13;
      default: begin ill = 1; return; end
    endcase
    if (op == 8'h0D && u > 255) begin
      nw = 2;
      w0 = 16'(15 * 4096 + int'(rd) * 256 + u / 256);
      w1 = 16'(2 * 4096 + int'(rd) * 256 + u % 256);
      return;
    end
    if (sgn ? (s < -128 || s > 127) : (u > 255)) begin
      rng = 1;
      return;
    end
    w0 = 16'(opc * 4096 + int'(rd) * 256 + u % 256);
  endfunction

  task automatic model_reset();
    m_base = 0; m_count = 0; m_ill = 0; m_rng = 0; m_two = 0; m_ori = 16'h0;
    x_we = 0; x_addr = 0; x_data = 16'h0;
  endtask

  task automatic emit(input logic [15:0] w);
    x_we = 1;
    x_addr = (m_base + m_count) % 256;
    x_data = w;
    m_count++;
  endtask

  task automatic check_outputs();
    chk("mem_we", mem_we, x_we);
    chk("mem_addr", mem_addr, x_addr);
    chk("mem_wdata", mem_wdata, x_data);
    chk("word_count", word_count, m_count);
    chk("full", full, m_count == DEPTH);
    chk("err_illegal", err_illegal, m_ill);
    chk("err_range", err_range, m_rng);
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input bit v, input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [15:0] imm, input bit ri, input bit ld, input logic [7:0] base);
    bit ill, rng, rdy;
    int nw;
    logic [15:0] w0, w1;
    in_valid = v; in_op = op; in_rdest = rd; in_rsrc = rs; in_imm = imm; in_ri = ri;
    addr_load = ld; base_addr = base;
    #1;
    rdy = !ld && !m_two && m_count < DEPTH;
    chk("in_ready", in_ready, rdy);
    x_we = 0;
    if (ld) begin
      m_base = int'(base); m_count = 0; m_ill = 0; m_rng = 0; m_two = 0;
    end else if (m_two) begin
      emit(m_ori);
      m_two = 0;
    end else if (v && rdy) begin
      encode(op, rd, rs, imm, ri, ill, rng, nw, w0, w1);
      if (ill) m_ill = 1;
      else if (rng || (nw == 2 && m_count > DEPTH - 2)) m_rng = 1;
      else begin
        emit(w0);
        if (nw == 2) begin m_two = 1; m_ori = w1; end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    addr_load = 0;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 8'h00, 4'h0, 4'h0, 16'h0, 0, 0, 8'h00);
  endtask

  task automatic load(input logic [7:0] base);
    step(0, 8'h00, 4'h0, 4'h0, 16'h0, 0, 1, base);
  endtask

  task automatic do_reset();
    reset_n = 0;
    in_valid = 1;
    #1;
    model_reset();
    chk("rst_in_ready", in_ready, 1'b0);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset_n = 1;
    in_valid = 0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    load(8'h10);
    step(1, 8'h05, 4'd3, 4'd5, 16'h0, 0, 0, 8'h00);
    chk("add_reg_word", mem_wdata, 16'h0355);
    chk("add_reg_addr", mem_addr, 8'h10);
    step(1, 8'h05, 4'd2, 4'd0, 16'hFFFD, 1, 0, 8'h00);
    chk("addi_word", mem_wdata, 16'h52FD);
    step(1, 8'h01, 4'd1, 4'd0, 16'h00F0, 1, 0, 8'h00);
    chk("andi_word", mem_wdata, 16'h11F0);
    chk("andi_addr", mem_addr, 8'h12);
    load(8'h20);
    step(1, 8'h0D, 4'd4, 4'd0, 16'h1234, 1, 0, 8'h00);
    chk("lui_word", mem_wdata, 16'hF412);
    chk("lui_ready_low", in_ready, 1'b0);
    idle();
    chk("ori_word", mem_wdata, 16'h2434);
    chk("ori_addr", mem_addr, 8'h21);
    idle();
    step(1, 8'h05, 4'd1, 4'd0, 16'h0080, 1, 0, 8'h00);
    chk("range_flag", err_range, 1'b1);
    step(1, 8'h84, 4'd1, 4'd0, 16'h0001, 1, 0, 8'h00);
    chk("illegal_flag", err_illegal, 1'b1);
    load(8'h30);
    chk("flags_cleared", {err_illegal, err_range}, 2'b00);
    load(8'hFE);
    for (int i = 0; i < 4; i++) step(1, 8'h02, 4'(i), 4'd7, 16'h0, 0, 0, 8'h00);
    chk("wrap_addr", mem_addr, 8'h01);
    chk("full_set", full, 1'b1);
    step(1, 8'h05, 4'd1, 4'd1, 16'h0, 0, 0, 8'h00);
    chk("full_blocks", mem_we, 1'b0);
    load(8'h00);
    for (int i = 0; i < 3; i++) step(1, 8'h09, 4'd2, 4'(i), 16'h0, 0, 0, 8'h00);
    step(1, 8'h0D, 4'd5, 4'd0, 16'hABCD, 1, 0, 8'h00);
    chk("mov_no_room", err_range, 1'b1);
    load(8'h40);
    step(1, 8'h0D, 4'd6, 4'd0, 16'h5566, 1, 0, 8'h00);
    load(8'h50);
    chk("load_drops_ori", mem_we, 1'b0);
    idle();
    load(8'h60);
    step(1, 8'h0D, 4'd7, 4'd0, 16'h7788, 1, 0, 8'h00);
    do_reset();
    for (int n = 0; n < 500; n++) begin
      int k;
      logic [15:0] imm;
      k = $urandom % 4;
      imm = (k == 0) ? 16'($urandom_range(0, 255)) : (k == 1) ? 16'(-$urandom_range(1, 129)) :
            (k == 2) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      step(($urandom % 4) != 0, ops[$urandom % 12], 4'($urandom), 4'($urandom), imm,
           1'($urandom), ($urandom % 12) == 0, 8'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
